// File: rtl/mux_pkg.sv
// Shared constants and helpers for the valid/ready multiplexer family.
package mux_pkg;

   localparam int MAX_MUX_IN = 16;

   // Width of a channel index; never narrower than one bit.
   function automatic int src_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Channel visited at position 'off' of a rotating search that starts after 'base'.
   function automatic int rr_index(input int base, input int off, input int n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter with an optional grant lock onto one channel.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter  int NUM_IN = 4,
   localparam int SRC_W  = src_width(NUM_IN)
) (
   input  logic [NUM_IN-1:0] req,
   input  logic [SRC_W-1:0]  last_grant,
   input  logic              lock,
   input  logic [SRC_W-1:0]  lock_idx,
   output logic [NUM_IN-1:0] grant,
   output logic [SRC_W-1:0]  grant_idx,
   output logic              any_grant
);

   logic [SRC_W-1:0] cand [NUM_IN];

   // cand[k] is the k-th channel in search order, beginning just after last_grant.
   for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_cand
      assign cand[gi] = SRC_W'(rr_index(int'(last_grant), gi + 1, NUM_IN));
   end

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      if (lock) begin
         // A locked packet owns the output even if its source pauses.
         if (req[lock_idx]) begin
            grant[lock_idx] = 1'b1;
            grant_idx       = lock_idx;
            any_grant       = 1'b1;
         end
      end else begin
         for (int k = 0; k < NUM_IN; k++) begin
            if (!any_grant && req[cand[k]]) begin
               grant[cand[k]] = 1'b1;
               grant_idx      = cand[k];
               any_grant      = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/rr_mux.sv
// N-input valid/ready round-robin multiplexer with one registered output stage.
// Define RR_MUX_LOCK_EN to add in_last and hold the grant for multi-beat packets.
module rr_mux
   import mux_pkg::*;
#(
   parameter  int NUM_IN = 4,
   parameter  int WIDTH  = 32,
   localparam int SRC_W  = src_width(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_IN-1:0]       in_valid,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
`ifdef RR_MUX_LOCK_EN
   input  logic [NUM_IN-1:0]       in_last,
`endif
   output logic [NUM_IN-1:0]       in_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [SRC_W-1:0]        out_src,
   input  logic                    out_ready
);

   logic             out_valid_reg;
   logic [WIDTH-1:0] out_data_reg;
   logic [SRC_W-1:0] out_src_reg;
   logic [SRC_W-1:0] last_grant_reg;

   logic [WIDTH-1:0]  chan_data [NUM_IN];
   logic [NUM_IN-1:0] grant;
   logic [SRC_W-1:0]  grant_idx;
   logic              any_grant;
   logic              load;
   logic              xfer;
   logic              lock;

   for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_chan
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi]  = grant[gi] & load;
   end

   assign load = !out_valid_reg | out_ready;
   // A granted channel is always valid, so a grant plus a free register is a handshake.
   assign xfer = any_grant & load;

`ifdef RR_MUX_LOCK_EN
   logic lock_active_reg;

   always_ff @(posedge clk) begin
      if (reset)
         lock_active_reg <= 1'b0;
      else if (xfer)
         lock_active_reg <= !in_last[grant_idx];
   end

   assign lock = lock_active_reg;
`else
   assign lock = 1'b0;
`endif

   // The locked channel is always the most recently accepted one.
   rr_arbiter #(
      .NUM_IN     (NUM_IN)
   ) u_arb (
      .req        (in_valid),
      .last_grant (last_grant_reg),
      .lock       (lock),
      .lock_idx   (last_grant_reg),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .any_grant  (any_grant)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_reg  <= 1'b0;
         out_data_reg   <= '0;
         out_src_reg    <= '0;
         last_grant_reg <= SRC_W'(NUM_IN - 1);
      end else if (xfer) begin
         out_valid_reg  <= 1'b1;
         out_data_reg   <= chan_data[grant_idx];
         out_src_reg    <= grant_idx;
         last_grant_reg <= grant_idx;
      end else if (out_ready) begin
         out_valid_reg  <= 1'b0;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_src   = out_src_reg;

endmodule

// File: tb/tb_rr_mux.sv
// Directed bench for rr_mux (NUM_IN=4, WIDTH=32); follows RR_MUX_LOCK_EN when defined.
module tb_rr_mux;

   logic         clk;
   logic         reset;
   logic [3:0]   in_valid;
   logic [127:0] in_data;
   logic [3:0]   in_ready;
   logic         out_valid;
   logic [31:0]  out_data;
   logic [1:0]   out_src;
   logic         out_ready;
`ifdef RR_MUX_LOCK_EN
   logic [3:0]   in_last;
`endif

   int checks;
   int failures;
   int ch2_sent;
   int exp_seq [4];

   rr_mux #(
      .NUM_IN    (4),
      .WIDTH     (32)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
`ifdef RR_MUX_LOCK_EN
      .in_last   (in_last),
`endif
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic std_data();
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hC0DE_0000 | i;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      in_valid  = 4'b0000;
      in_data   = '0;
      out_ready = 1'b0;
`ifdef RR_MUX_LOCK_EN
      in_last   = 4'b1111;
`endif

      // Reset then idle
      tick();
      tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_out_src", 32'(out_src), 32'd0);
      reset = 1'b0;
      #1;
      chk("idle_in_ready", 32'(in_ready), 32'h0);

      in_valid = 4'b0001;
      in_data[31:0] = 32'hA5A5_0001;
      out_ready = 1'b1;
      #1;
      chk("first_in_ready", 32'(in_ready), 32'h1);
      tick();
      chk("first_out_valid", 32'(out_valid), 32'd1);
      chk("first_out_data", out_data, 32'hA5A5_0001);
      chk("first_out_src", 32'(out_src), 32'd0);
      in_valid = 4'b0000;
      tick();
      chk("drain_out_valid", 32'(out_valid), 32'd0);
      chk("drain_data_held", out_data, 32'hA5A5_0001);

      // Round-robin fairness from a fresh reset
      reset = 1'b1;
      tick();
      reset = 1'b0;
      std_data();
      in_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("rr_out_valid", 32'(out_valid), 32'd1);
         chk("rr_out_src", 32'(out_src), 32'(k % 4));
         chk("rr_out_data", out_data, 32'hC0DE_0000 | 32'(k % 4));
      end

      // Back-pressure with channels 1 and 2 pending
      out_ready = 1'b0;
      in_valid  = 4'b0110;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_in_ready", 32'(in_ready), 32'h0);
         tick();
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_out_data", out_data, 32'hC0DE_0003);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_rel_in_ready", 32'(in_ready), 32'h2);
      tick();
      chk("bp_rel_src1", 32'(out_src), 32'd1);
      chk("bp_rel_in_ready2", 32'(in_ready), 32'h4);
      tick();
      chk("bp_rel_src2", 32'(out_src), 32'd2);
      in_valid = 4'b0000;
      tick();
      chk("bp_drain_valid", 32'(out_valid), 32'd0);

      // Priority retention across a stall
      in_valid = 4'b0010;
      tick();
      chk("pr_src1", 32'(out_src), 32'd1);
      out_ready = 1'b0;
      in_valid  = 4'b1000;
      #1;
      chk("pr_stall_in_ready", 32'(in_ready), 32'h0);
      tick();
      tick();
      chk("pr_stall_src", 32'(out_src), 32'd1);
      out_ready = 1'b1;
      #1;
      chk("pr_rel_in_ready", 32'(in_ready), 32'h8);
      tick();
      chk("pr_src3", 32'(out_src), 32'd3);
      in_valid = 4'b1001;
      #1;
      chk("pr_wrap_in_ready", 32'(in_ready), 32'h1);
      tick();
      chk("pr_wrap_src0", 32'(out_src), 32'd0);
      chk("pr_wrap_data", out_data, 32'hC0DE_0000);

      // Reset while stalled with a beat held
      in_valid  = 4'b1111;
      out_ready = 1'b0;
      reset     = 1'b1;
      tick();
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_data", out_data, 32'h0);
      reset     = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("mid_rst_in_ready", 32'(in_ready), 32'h1);
      tick();
      chk("mid_rst_src", 32'(out_src), 32'd0);

      // Channel 2 sends a three-beat packet while channel 0 keeps requesting
`ifdef RR_MUX_LOCK_EN
      exp_seq = '{2, 2, 2, 0};
`else
      exp_seq = '{2, 0, 2, 0};
`endif
      ch2_sent = 0;
      in_valid = 4'b0101;
      for (int k = 0; k < 4; k++) begin
`ifdef RR_MUX_LOCK_EN
         in_last = (ch2_sent == 2) ? 4'b1111 : 4'b1011;
`endif
         in_valid[2] = (ch2_sent < 3);
         tick();
         chk("pkt_src", 32'(out_src), 32'(exp_seq[k]));
         chk("pkt_data", out_data, 32'hC0DE_0000 | 32'(exp_seq[k]));
         if (exp_seq[k] == 2) ch2_sent++;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
